// File: rtl/assert_event_monitor_if.sv
// Verdict bus from the assertion checks and the failure-log read port.
// The master side drives verdicts and pops; the monitor is the slave side.
interface assert_event_monitor_if #(
    parameter int ID_W  = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
);
    logic                     chk_valid;
    logic                     chk_pass;
    logic [ID_W-1:0]          chk_id;
    logic                     rd_en;
    logic                     log_valid;
    logic [ID_W-1:0]          log_id;
    logic [TS_W-1:0]          log_ts;
    logic [$clog2(DEPTH):0]   log_count;

    modport master (
        output chk_valid, chk_pass, chk_id, rd_en,
        input  log_valid, log_id, log_ts, log_count
    );

    modport slave (
        input  chk_valid, chk_pass, chk_id, rd_en,
        output log_valid, log_id, log_ts, log_count
    );
endinterface

// File: rtl/assert_event_monitor.sv
// Assertion verdict monitor: saturating pass/fail counters, timestamped
// failure log FIFO, first-failure capture and a halt request at a fail threshold.
//
//   state | meaning
//   IDLE  | monitoring disabled, verdicts ignored, ts held
//   RUN   | monitoring, no failure since last enable/clear
//   FAIL  | monitoring, at least one failure seen
//   HALT  | fail threshold reached, halt_req high, only clr/rst_n leave
module assert_event_monitor #(
    parameter int ID_W     = 4,
    parameter int TS_W     = 16,
    parameter int CNT_W    = 8,
    parameter int DEPTH    = 4,
    parameter int HALT_THR = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    assert_event_monitor_if.slave bus,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 ovf,
    output logic                 first_fail_vld,
    output logic [ID_W-1:0]      first_fail_id,
    output logic [1:0]           state_o,
    output logic                 halt_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FAIL = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TS_W-1:0]     ts;
    logic [ID_W-1:0]     mem_id [DEPTH];
    logic [TS_W-1:0]     mem_ts [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       count;

    logic                active;
    logic                accept;
    logic                pass_hit;
    logic                fail_hit;
    logic                thr_hit;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                drop;
    logic [CNT_W-1:0]    fail_cnt_inc;

    assign active       = (state == RUN) || (state == FAIL);
    assign accept       = bus.chk_valid && active;
    assign pass_hit     = accept && bus.chk_pass;
    assign fail_hit     = accept && !bus.chk_pass;
    assign fail_cnt_inc = (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;
    assign thr_hit      = fail_hit && (fail_cnt_inc >= CNT_W'(HALT_THR));

    // A pop frees the slot the same edge, so a full FIFO still takes the push.
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = bus.rd_en && (count != '0);
    assign do_push = fail_hit && (!full || do_pop);
    assign drop    = fail_hit && full && !do_pop;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (thr_hit)       state_nxt = HALT;
                else if (!en)      state_nxt = IDLE;
                else if (fail_hit) state_nxt = FAIL;
            end
            FAIL: begin
                if (thr_hit)       state_nxt = HALT;
                else if (!en)      state_nxt = IDLE;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ts             <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            ovf            <= 1'b0;
            first_fail_vld <= 1'b0;
            first_fail_id  <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_id[i] <= '0;
                mem_ts[i] <= '0;
            end
        end else begin
            if (active) ts <= ts + 1'b1;

            if (pass_hit && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
            if (fail_hit) fail_cnt <= fail_cnt_inc;

            if (fail_hit && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_id  <= bus.chk_id;
            end

            if (drop) ovf <= 1'b1;

            if (do_push) begin
                mem_id[wr_ptr] <= bus.chk_id;
                mem_ts[wr_ptr] <= ts;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;

            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.log_valid = (count != '0);
    assign bus.log_id    = mem_id[rd_ptr];
    assign bus.log_ts    = mem_ts[rd_ptr];
    assign bus.log_count = count;
    assign state_o       = state;
    assign halt_req      = (state == HALT);

endmodule

// File: tb/tb_assert_event_monitor.sv
// Directed bench for assert_event_monitor: three instances cover the default
// threshold, a deep-threshold FIFO overflow case and a 2-bit saturating counter.
module tb_assert_event_monitor;

    logic       clk = 1'b0;
    logic       rst0, rst1, rst2;
    logic       en, clr, chk_valid, chk_pass, rd_en;
    logic [3:0] chk_id;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assert_event_monitor_if #(.ID_W(4), .TS_W(16), .DEPTH(4)) b0 ();
    assert_event_monitor_if #(.ID_W(4), .TS_W(16), .DEPTH(4)) b1 ();
    assert_event_monitor_if #(.ID_W(4), .TS_W(16), .DEPTH(4)) b2 ();

    assign b0.chk_valid = chk_valid;
    assign b0.chk_pass  = chk_pass;
    assign b0.chk_id    = chk_id;
    assign b0.rd_en     = rd_en;
    assign b1.chk_valid = chk_valid;
    assign b1.chk_pass  = chk_pass;
    assign b1.chk_id    = chk_id;
    assign b1.rd_en     = rd_en;
    assign b2.chk_valid = chk_valid;
    assign b2.chk_pass  = chk_pass;
    assign b2.chk_id    = chk_id;
    assign b2.rd_en     = rd_en;

    logic [7:0] pc0, fc0, pc1, fc1;
    logic [1:0] pc2, fc2;
    logic       ovf0, ovf1, ovf2, ffv0, ffv1, ffv2, halt0, halt1, halt2;
    logic [3:0] ffid0, ffid1, ffid2;
    logic [1:0] st0, st1, st2;

    assert_event_monitor #(.ID_W(4), .TS_W(16), .CNT_W(8), .DEPTH(4), .HALT_THR(3)) u0 (
        .clk(clk), .rst_n(rst0), .en(en), .clr(clr), .bus(b0),
        .pass_cnt(pc0), .fail_cnt(fc0), .ovf(ovf0), .first_fail_vld(ffv0),
        .first_fail_id(ffid0), .state_o(st0), .halt_req(halt0));

    assert_event_monitor #(.ID_W(4), .TS_W(16), .CNT_W(8), .DEPTH(4), .HALT_THR(10)) u1 (
        .clk(clk), .rst_n(rst1), .en(en), .clr(clr), .bus(b1),
        .pass_cnt(pc1), .fail_cnt(fc1), .ovf(ovf1), .first_fail_vld(ffv1),
        .first_fail_id(ffid1), .state_o(st1), .halt_req(halt1));

    assert_event_monitor #(.ID_W(4), .TS_W(16), .CNT_W(2), .DEPTH(4), .HALT_THR(3)) u2 (
        .clk(clk), .rst_n(rst2), .en(en), .clr(clr), .bus(b2),
        .pass_cnt(pc2), .fail_cnt(fc2), .ovf(ovf2), .first_fail_vld(ffv2),
        .first_fail_id(ffid2), .state_o(st2), .halt_req(halt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic pass, input logic [3:0] id, input logic rd);
        chk_valid = 1'b1;
        chk_pass  = pass;
        chk_id    = id;
        rd_en     = rd;
        tick();
        chk_valid = 1'b0;
        chk_pass  = 1'b0;
        chk_id    = 4'd0;
        rd_en     = 1'b0;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        en = 1'b0; clr = 1'b0; chk_valid = 1'b0; chk_pass = 1'b0;
        chk_id = 4'd0; rd_en = 1'b0;
        tick();
        tick();

        chk("rst_pass_cnt", pc0, 0);
        chk("rst_fail_cnt", fc0, 0);
        chk("rst_log_valid", b0.log_valid, 0);
        chk("rst_log_count", b0.log_count, 0);
        chk("rst_log_id", b0.log_id, 0);
        chk("rst_log_ts", b0.log_ts, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_ffv", ffv0, 0);
        chk("rst_ffid", ffid0, 0);
        chk("rst_state", st0, 0);
        chk("rst_halt", halt0, 0);

        // 1: five passes
        rst0 = 1'b1;
        en = 1'b1;
        tick();
        chk("t1_enter_run", st0, 1);
        for (int i = 1; i <= 5; i++) send(1'b1, 4'(i), 1'b0);
        chk("t1_pass_cnt", pc0, 5);
        chk("t1_fail_cnt", fc0, 0);
        chk("t1_state", st0, 1);
        chk("t1_log_valid", b0.log_valid, 0);
        chk("t1_ffv", ffv0, 0);

        // 2: first fail at ts=3, later fail does not overwrite
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t2_clr_state", st0, 0);
        chk("t2_clr_pass", pc0, 0);
        tick();
        tick(); tick(); tick();
        send(1'b0, 4'd7, 1'b0);
        chk("t2_state", st0, 2);
        chk("t2_log_count", b0.log_count, 1);
        chk("t2_log_id", b0.log_id, 7);
        chk("t2_log_ts", b0.log_ts, 3);
        chk("t2_ffv", ffv0, 1);
        chk("t2_ffid", ffid0, 7);
        send(1'b0, 4'd9, 1'b0);
        chk("t2_ffid_kept", ffid0, 7);
        chk("t2_fail_cnt", fc0, 2);
        chk("t2_log_count2", b0.log_count, 2);
        chk("t2_head_kept", b0.log_id, 7);
        chk("t2_state2", st0, 2);

        // 3: threshold reaches HALT, HALT ignores verdicts and en, clr recovers
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        send(1'b0, 4'd2, 1'b0);
        send(1'b0, 4'd4, 1'b0);
        send(1'b0, 4'd6, 1'b0);
        chk("t3_halt", halt0, 1);
        chk("t3_state", st0, 3);
        chk("t3_fail_cnt", fc0, 3);
        chk("t3_log_count", b0.log_count, 3);
        chk("t3_head", b0.log_id, 2);
        en = 1'b0;
        send(1'b0, 4'd8, 1'b0);
        chk("t3_ignored_cnt", fc0, 3);
        chk("t3_ignored_log", b0.log_count, 3);
        chk("t3_still_halt", st0, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr_state", st0, 0);
        chk("t3_clr_halt", halt0, 0);
        chk("t3_clr_fail", fc0, 0);
        chk("t3_clr_count", b0.log_count, 0);
        chk("t3_clr_ffv", ffv0, 0);
        chk("t3_clr_ffid", ffid0, 0);

        // 5: empty pop, en drop retains state, ts resumes from held value
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_empty_pop_count", b0.log_count, 0);
        chk("t5_empty_pop_valid", b0.log_valid, 0);
        en = 1'b1;
        tick();
        send(1'b1, 4'd1, 1'b0);
        send(1'b1, 4'd2, 1'b0);
        en = 1'b0;
        tick();
        chk("t5_idle", st0, 0);
        send(1'b1, 4'd3, 1'b0);
        chk("t5_pass_kept", pc0, 2);
        chk("t5_idle_kept", st0, 0);
        en = 1'b1;
        tick();
        chk("t5_resume", st0, 1);
        send(1'b0, 4'd5, 1'b0);
        chk("t5_ts_resumed", b0.log_ts, 3);
        chk("t5_log_id", b0.log_id, 5);
        chk("t5_pass_after", pc0, 2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_pop_count", b0.log_count, 0);
        chk("t5_pop_valid", b0.log_valid, 0);

        // 4: overflow with HALT_THR=10, then push+pop while full
        en = 1'b0;
        rst0 = 1'b0;
        rst1 = 1'b1;
        tick();
        en = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) send(1'b0, 4'(i), 1'b0);
        chk("t4_log_count", b1.log_count, 4);
        chk("t4_ovf", ovf1, 1);
        chk("t4_fail_cnt", fc1, 5);
        chk("t4_head_id", b1.log_id, 1);
        chk("t4_head_ts", b1.log_ts, 0);
        chk("t4_state", st1, 2);
        send(1'b0, 4'd12, 1'b1);
        chk("t4_full_rw_count", b1.log_count, 4);
        chk("t4_full_rw_head", b1.log_id, 2);
        chk("t4_full_rw_ts", b1.log_ts, 1);
        chk("t4_full_rw_fail", fc1, 6);
        chk("t4_ovf_sticky", ovf1, 1);
        rd_en = 1'b1;
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("t4_tail_id", b1.log_id, 12);
        chk("t4_tail_ts", b1.log_ts, 5);
        chk("t4_tail_count", b1.log_count, 1);

        // 6: 2-bit counters saturate, reset from HALT
        en = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b1;
        tick();
        en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send(1'b1, 4'(i), 1'b0);
        chk("t6_pass_sat", pc2, 3);
        send(1'b0, 4'd1, 1'b0);
        send(1'b0, 4'd2, 1'b0);
        send(1'b0, 4'd3, 1'b0);
        chk("t6_state_halt", st2, 3);
        chk("t6_halt", halt2, 1);
        chk("t6_fail_cnt", fc2, 3);
        rst2 = 1'b0;
        tick();
        chk("t6_rst_state", st2, 0);
        chk("t6_rst_halt", halt2, 0);
        chk("t6_rst_pass", pc2, 0);
        chk("t6_rst_fail", fc2, 0);
        chk("t6_rst_count", b2.log_count, 0);
        chk("t6_rst_valid", b2.log_valid, 0);
        chk("t6_rst_ffv", ffv2, 0);
        chk("t6_rst_ffid", ffid2, 0);
        chk("t6_rst_ovf", ovf2, 0);
        chk("t6_rst_log_id", b2.log_id, 0);
        chk("t6_rst_log_ts", b2.log_ts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/assert_event_monitor.md
Name: assert_event_monitor

Overview:
- Sits directly downstream of the deferred immediate assertion checks in the verification environment.
- Each check reports a pass/fail verdict with a check ID once per evaluation; this block consumes those verdicts.
- It counts passes and fails, timestamps and buffers failures in a small log FIFO, and captures the first failure.
- It raises a halt request once a failure threshold is reached, so the bench can stop the simulation cleanly.

Parameters:
- ID_W, 4: width of check identifier.
- TS_W, 16: width of the free-running cycle timestamp.
- CNT_W, 8: width of the pass and fail counters (saturating).
- DEPTH, 4: failure-log FIFO depth; must be a power of 2, at least 2.
- HALT_THR, 3: fail count at which halt_req asserts; range 1..2^CNT_W-1.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- en, in, 1: monitoring enable.
- clr, in, 1: synchronous soft clear.
- chk_valid, in, 1: a check verdict is presented this cycle.
- chk_pass, in, 1: 1 = pass, 0 = fail; qualified by chk_valid.
- chk_id, in, ID_W: identifier of the reporting check.
- rd_en, in, 1: pop the failure-log head.
- pass_cnt, out, CNT_W: accepted passes.
- fail_cnt, out, CNT_W: accepted fails.
- log_valid, out, 1: FIFO non-empty.
- log_id, out, ID_W: head entry ID.
- log_ts, out, TS_W: head entry timestamp.
- log_count, out, $clog2(DEPTH)+1: number of FIFO entries.
- ovf, out, 1: sticky; a failure was dropped because the FIFO was full.
- first_fail_vld, out, 1: sticky; a first failure has been captured.
- first_fail_id, out, ID_W: ID of the first failure.
- state_o, out, 2: FSM state.
- halt_req, out, 1: high in HALT.

Behaviour:
- Reset (rst_n=0 at a rising edge) values:
  - all counters, ts, FIFO pointers and log_count = 0.
  - log_valid, ovf, first_fail_vld, halt_req = 0.
  - log_id, log_ts, first_fail_id = 0.
  - state_o = IDLE (2'b00).
- Priority order: rst_n > clr > everything else.
- clr=1: same effect as reset; the state returns to IDLE.
- Timestamp ts increments by 1 every cycle while state is RUN or FAIL, and wraps at 2^TS_W-1 -> 0.
- An event is accepted when chk_valid=1 and state is RUN or FAIL. Otherwise chk_* inputs are ignored.
- FSM:
  - IDLE (00): en=1 -> RUN. No events accepted.
  - RUN (01): accepted fail -> FAIL. en=0 -> IDLE.
  - FAIL (10): fail_cnt reaches HALT_THR -> HALT. en=0 -> IDLE.
  - HALT (11): halt_req=1; no events accepted; en is ignored. Exit only via clr or rst_n.
  - On an en=0 transition to IDLE, counters, FIFO and sticky flags are retained. Re-enabling resumes in RUN even if fails were recorded.
- Latency: an event sampled at edge N updates counters, the FIFO, first_fail and state at edge N. Outputs are visible the following cycle. All outputs are registered.
- A fail that makes fail_cnt equal HALT_THR (including from RUN when HALT_THR=1) is counted and logged. The state moves straight to HALT on that same edge.
- Counters saturate at 2^CNT_W-1; they never wrap.
- On an accepted fail, the entry {chk_id, ts} is pushed. The ts pushed is the value before this edge's increment.
- first_fail_id/first_fail_vld are captured on the first accepted fail since reset/clr. Later fails never overwrite them.
- FIFO is show-ahead: log_valid = (log_count != 0), and log_id/log_ts always present the head entry.
  - rd_en=1 with log_valid=1: pops at the edge.
  - rd_en with log_valid=0: ignored; no underflow.
  - Push and pop in the same cycle when full: both occur, count unchanged, ovf not set.
  - Push and pop in the same cycle when empty: the push occurs and the pop is ignored.
  - Push when full with no pop: the entry is dropped, ovf=1 (sticky), fail_cnt still increments.
  - Pointers wrap modulo DEPTH.
- rd_en remains functional in every state, including IDLE and HALT.

Test Plan:
1. Reset, en=1, then 5 passes (id 1..5) -> pass_cnt=5, fail_cnt=0, state=RUN, log_valid=0, first_fail_vld=0.
2. From RUN, fail id=7 at ts=3 -> state=FAIL, log_count=1, log_id=7, log_ts=3, first_fail_id=7; a further fail id=9 leaves first_fail_id=7.
3. HALT_THR=3, fails ids 2,4,6 -> halt_req=1, state=HALT, fail_cnt=3; a further chk_valid fail is ignored (fail_cnt stays 3); clr -> all zero, state=IDLE.
4. DEPTH=4, HALT_THR=10, 5 fails with no reads -> log_count=4, ovf=1, fail_cnt=5, head = first entry. Then a simultaneous fail+rd_en while full -> log_count=4, new entry at tail.
5. rd_en on empty -> no change. en dropped mid-RUN after 2 passes -> IDLE, pass_cnt=2 retained, chk_valid pass ignored. en=1 -> RUN and ts resumes from its held value.
6. CNT_W=2, HALT_THR=3, 6 passes -> pass_cnt=3 (saturated). rst_n=0 asserted while in HALT -> all outputs reset values the next cycle.
